// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state codes, default timeout and
// the word-alignment helper. The hazard unit imports the same package.
package mem_access_stage_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

   localparam int MAX_WAIT_DEF = 16;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return (lsb == 2'b00);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for the MEM stage: counts stalled cycles of one access
// and flags the cycle in which the access has used up its budget.
module mem_wait_timer #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = $clog2(MAX_WAIT)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests for loads/stores, stalls
// upstream on wait states, and registers results into MEM/WB.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REG_W    = 5,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] ALUout_i,
   input  logic [DATA_W-1:0] Op2_i,
   input  logic [REG_W-1:0]  RegDest_i,
   input  logic              RegWrite_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic              MemtoReg_i,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_o,
   output logic [DATA_W-1:0] MemData_o,
   output logic [DATA_W-1:0] ALUout_o,
   output logic [REG_W-1:0]  RegDest_o,
   output logic              regWrite_o,
   output logic              MemtoReg_o,
   output logic              err_misalign,
   output logic              err_timeout
);

   mem_state_e state_q, state_d;

   logic memop, is_load, aligned, req_ok, misalign;
   logic ack_hit, timeout, stall, expired;

   logic [DATA_W-1:0] mem_data_q, mem_data_d;
   logic [DATA_W-1:0] alu_out_q, alu_out_d;
   logic [REG_W-1:0]  reg_dest_q, reg_dest_d;
   logic              reg_write_q, reg_write_d;
   logic              memto_reg_q, memto_reg_d;
   logic              err_misalign_q, err_misalign_d;
   logic              err_timeout_q, err_timeout_d;

   mem_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (~stall),
      .inc     (stall),
      .expired (expired)
   );

   // Request decode and FSM next state. Reset gates the request so an
   // in-flight access is abandoned the moment reset rises.
   always_comb begin
      memop    = MemRead_i | MemWrite_i;
      is_load  = MemRead_i & ~MemWrite_i;
      aligned  = word_aligned(ALUout_i[1:0]);
      misalign = memop & ~aligned;
      req_ok   = memop & aligned & ~reset;
      ack_hit  = req_ok & mem_ack;
      timeout  = req_ok & ~mem_ack & (state_q == ST_WAIT) & expired;
      stall    = req_ok & ~mem_ack & ~timeout;
      state_d  = state_q;
      case (state_q)
         ST_IDLE: if (stall) state_d = ST_WAIT;
         ST_WAIT: if (!stall) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // MEM/WB next values: a stalled, misaligned or timed-out instruction is
   // turned into a bubble so it can never write back.
   always_comb begin
      alu_out_d      = ALUout_i;
      reg_dest_d     = RegDest_i;
      memto_reg_d    = MemtoReg_i;
      reg_write_d    = RegWrite_i & ~(stall | misalign | timeout);
      mem_data_d     = (ack_hit & is_load) ? mem_rdata : mem_data_q;
      err_misalign_d = err_misalign_q | misalign;
      err_timeout_d  = err_timeout_q | timeout;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_data_q     <= '0;
         alu_out_q      <= '0;
         reg_dest_q     <= '0;
         reg_write_q    <= 1'b0;
         memto_reg_q    <= 1'b0;
         err_misalign_q <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         mem_data_q     <= mem_data_d;
         alu_out_q      <= alu_out_d;
         reg_dest_q     <= reg_dest_d;
         reg_write_q    <= reg_write_d;
         memto_reg_q    <= memto_reg_d;
         err_misalign_q <= err_misalign_d;
         err_timeout_q  <= err_timeout_d;
      end
   end

   assign mem_req      = req_ok;
   assign mem_we       = req_ok & MemWrite_i;
   assign mem_addr     = ALUout_i;
   assign mem_wdata    = Op2_i;
   assign stall_o      = stall;
   assign MemData_o    = mem_data_q;
   assign ALUout_o     = alu_out_q;
   assign RegDest_o    = reg_dest_q;
   assign regWrite_o   = reg_write_q;
   assign MemtoReg_o   = memto_reg_q;
   assign err_misalign = err_misalign_q;
   assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed testbench for mem_access_stage: ALU pass-through, zero-wait load,
// multi-cycle store, misaligned access, timeout and reset during a wait.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ALUout_i, Op2_i, mem_rdata;
   logic [4:0]  RegDest_i;
   logic        RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, mem_ack;
   logic        mem_req, mem_we, stall_o, regWrite_o, MemtoReg_o;
   logic        err_misalign, err_timeout;
   logic [31:0] mem_addr, mem_wdata, MemData_o, ALUout_o;
   logic [4:0]  RegDest_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.DATA_W(32), .REG_W(5), .MAX_WAIT(16)) dut (
      .clk(clk), .reset(reset),
      .ALUout_i(ALUout_i), .Op2_i(Op2_i), .RegDest_i(RegDest_i),
      .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .MemtoReg_i(MemtoReg_i),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_o(stall_o), .MemData_o(MemData_o), .ALUout_o(ALUout_o),
      .RegDest_o(RegDest_o), .regWrite_o(regWrite_o), .MemtoReg_o(MemtoReg_o),
      .err_misalign(err_misalign), .err_timeout(err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic m2r);
      ALUout_i = addr; Op2_i = wd; RegDest_i = rd;
      RegWrite_i = rw; MemRead_i = mr; MemWrite_i = mw; MemtoReg_i = m2r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_stall;
      int n_req;
      reset = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("reset_mem_req", 32'(mem_req), 32'h0);
      chk("reset_stall", 32'(stall_o), 32'h0);
      chk("reset_regwrite", 32'(regWrite_o), 32'h0);
      chk("reset_errs", {30'h0, err_misalign, err_timeout}, 32'h0);
      tick();
      tick();
      reset = 1'b0;

      // ALU op: 1-cycle latency, no stall
      drive(32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("alu_stall", 32'(stall_o), 32'h0);
      chk("alu_req", 32'(mem_req), 32'h0);
      tick();
      chk("alu_aluout", ALUout_o, 32'h10);
      chk("alu_regdest", 32'(RegDest_o), 32'd5);
      chk("alu_regwrite", 32'(regWrite_o), 32'h1);

      // Load with zero wait states
      drive(32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      mem_ack = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      #1;
      chk("ld0_req", {30'h0, mem_req, mem_we}, 32'h2);
      chk("ld0_addr", mem_addr, 32'h100);
      chk("ld0_stall", 32'(stall_o), 32'h0);
      tick();
      chk("ld0_memdata", MemData_o, 32'hDEADBEEF);
      chk("ld0_memtoreg", 32'(MemtoReg_o), 32'h1);
      chk("ld0_regwrite", 32'(regWrite_o), 32'h1);
      chk("ld0_regdest", 32'(RegDest_o), 32'd7);

      // Store acked after 3 wait states
      mem_ack = 1'b0;
      mem_rdata = 32'h12345678;
      drive(32'h104, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_stall = 0;
      n_req = 0;
      for (int i = 0; i < 4; i++) begin
         mem_ack = (i == 3);
         #1;
         if (i == 0) chk("st_wdata", mem_wdata, 32'h55);
         if (mem_req && mem_we) n_req++;
         if (stall_o) n_stall++;
         tick();
         chk("st_regwrite", 32'(regWrite_o), 32'h0);
      end
      chk("st_req_cycles", 32'(n_req), 32'd4);
      chk("st_stall_cycles", 32'(n_stall), 32'd3);
      chk("st_memdata_kept", MemData_o, 32'hDEADBEEF);
      mem_ack = 1'b0;

      // Misaligned load
      drive(32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
      #1;
      chk("mis_req", 32'(mem_req), 32'h0);
      chk("mis_stall", 32'(stall_o), 32'h0);
      tick();
      chk("mis_err", 32'(err_misalign), 32'h1);
      chk("mis_regwrite", 32'(regWrite_o), 32'h0);
      chk("mis_aluout", ALUout_o, 32'h102);
      chk("mis_no_timeout", 32'(err_timeout), 32'h0);

      // Load that never gets acked
      drive(32'h200, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      n_stall = 0;
      for (int i = 0; i < 16; i++) begin
         #1;
         if (stall_o) n_stall++;
         tick();
      end
      chk("to_stall_cycles", 32'(n_stall), 32'd15);
      chk("to_err", 32'(err_timeout), 32'h1);
      chk("to_regwrite", 32'(regWrite_o), 32'h0);
      drive(32'h20, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("to_idle_stall", 32'(stall_o), 32'h0);
      tick();
      chk("to_idle_regwrite", 32'(regWrite_o), 32'h1);
      chk("to_misalign_sticky", 32'(err_misalign), 32'h1);

      // Reset asserted during the second wait cycle
      drive(32'h300, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      tick();
      chk("rst_in_wait_stall", 32'(stall_o), 32'h1);
      reset = 1'b1;
      #1;
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_stall", 32'(stall_o), 32'h0);
      chk("rst_aluout", ALUout_o, 32'h0);
      chk("rst_errs", {30'h0, err_misalign, err_timeout}, 32'h0);
      tick();
      reset = 1'b0;
      drive(32'h40, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      mem_ack = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      #1;
      chk("late_ack_req", 32'(mem_req), 32'h0);
      tick();
      chk("late_ack_memdata", MemData_o, 32'h0);
      chk("late_ack_aluout", ALUout_o, 32'h40);
      mem_ack = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
